// File: rtl/hex_scroll_decoder.sv
// Read-back monitor for the 8-digit HEX scroller: decodes digits, checks HELLO rotation and scroll step.
// Define HEX_SCROLL_DEC_ERRCNT_EN to add the saturating err_cnt output.
module hex_scroll_decoder #(
    parameter int NDIG   = 8,
    parameter int CODE_W = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [6:0]               seg_in,
    input  logic                     seg_valid,
    input  logic                     seg_last,
    output logic [NDIG*CODE_W-1:0]   frame_codes,
    output logic                     frame_done,
    output logic                     hello_match,
    output logic [2:0]               rot_idx,
    output logic                     step_ok,
    output logic                     frame_err
`ifdef HEX_SCROLL_DEC_ERRCNT_EN
    ,
    output logic [7:0]               err_cnt
`endif
);
    localparam int IW = $clog2(NDIG);
    localparam logic [NDIG*CODE_W-1:0] MSG =
        {4'd4, 4'd4, 4'd4, 4'd3, 4'd2, 4'd2, 4'd1, 4'd0};
    localparam logic [CODE_W-1:0] BAD = {CODE_W{1'b1}};

    typedef enum logic {S_COLLECT, S_DROP} state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [IW-1:0]                r_idx;
    logic [(NDIG-1)*CODE_W-1:0]   r_asm;
    logic [NDIG*CODE_W-1:0]       r_frame;
    logic                         r_done;
    logic                         r_match;
    logic [2:0]                   r_rot;
    logic                         r_step;
    logic                         r_err;
    logic                         r_pmatch;
    logic [2:0]                   r_prot;

    logic [CODE_W-1:0]            w_code;
    logic [NDIG*CODE_W-1:0]       w_frame;
    logic [NDIG-1:0]              w_rot_hit;
    logic                         w_hit;
    logic                         w_bad;
    logic [2:0]                   w_rot;
    logic                         w_step;
    logic                         w_last_slot;
    logic                         w_wr;
    logic                         w_done;
    logic                         w_ferr;
    logic                         w_clr;
    logic                         w_err_pulse;

    // Patterns are compared active-high after inverting the bus.
    always_comb begin
        w_code = BAD;
        case (~seg_in)
            7'b0110111: w_code = 4'd0;
            7'b1001111: w_code = 4'd1;
            7'b0001110: w_code = 4'd2;
            7'b1111110: w_code = 4'd3;
            7'b0000000: w_code = 4'd4;
            default:    w_code = BAD;
        endcase
    end

    assign w_last_slot = (r_idx == IW'(NDIG - 1));
    assign w_frame     = {w_code, r_asm};

    function automatic logic [NDIG*CODE_W-1:0] rot_msg(input int r);
        rot_msg = '0;
        for (int k = 0; k < NDIG; k++)
            rot_msg[k*CODE_W +: CODE_W] = MSG[((k + r) % NDIG)*CODE_W +: CODE_W];
    endfunction

    for (genvar gr = 0; gr < NDIG; gr++) begin : g_rot
        assign w_rot_hit[gr] = (w_frame == rot_msg(gr));
    end

    always_comb begin
        w_hit = |w_rot_hit;
        w_rot = 3'd0;
        w_bad = 1'b0;
        for (int r = NDIG - 1; r >= 0; r--)
            if (w_rot_hit[r]) w_rot = 3'(r);
        for (int k = 0; k < NDIG; k++)
            if (w_frame[k*CODE_W +: CODE_W] == BAD) w_bad = 1'b1;
    end

    assign w_step      = w_hit && r_pmatch && (w_rot == r_prot + 3'd1);
    assign w_err_pulse = w_ferr | (w_done & w_bad);

    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_done      = 1'b0;
        w_ferr      = 1'b0;
        w_clr       = 1'b0;
        unique case (r_state)
            S_COLLECT: begin
                if (seg_valid) begin
                    if (seg_last && w_last_slot) begin
                        w_done = 1'b1;
                        w_clr  = 1'b1;
                    end else if (seg_last) begin
                        // The short frame already ended on this beat.
                        w_ferr = 1'b1;
                        w_clr  = 1'b1;
                    end else if (w_last_slot) begin
                        w_ferr      = 1'b1;
                        w_clr       = 1'b1;
                        w_state_nxt = S_DROP;
                    end else begin
                        w_wr = 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (seg_valid && seg_last) begin
                    w_clr       = 1'b1;
                    w_state_nxt = S_COLLECT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_COLLECT;
            r_idx    <= '0;
            r_asm    <= '0;
            r_frame  <= '0;
            r_done   <= 1'b0;
            r_match  <= 1'b0;
            r_rot    <= 3'd0;
            r_step   <= 1'b0;
            r_err    <= 1'b0;
            r_pmatch <= 1'b0;
            r_prot   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done;
            r_err   <= w_err_pulse;
            if (w_wr) begin
                r_asm[r_idx*CODE_W +: CODE_W] <= w_code;
                r_idx <= r_idx + 1'b1;
            end
            if (w_clr) r_idx <= '0;
            if (w_done) begin
                r_frame  <= w_frame;
                r_match  <= w_hit;
                r_rot    <= w_hit ? w_rot : 3'd0;
                r_step   <= w_step;
                r_pmatch <= w_hit;
                r_prot   <= w_rot;
            end else if (w_ferr) begin
                r_pmatch <= 1'b0;
            end
        end
    end

    assign frame_codes = r_frame;
    assign frame_done  = r_done;
    assign hello_match = r_match;
    assign rot_idx     = r_rot;
    assign step_ok     = r_step;
    assign frame_err   = r_err;

`ifdef HEX_SCROLL_DEC_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_err_cnt <= 8'd0;
        else if (w_err_pulse && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_hex_scroll_decoder.sv
// Bench for hex_scroll_decoder: directed scenarios plus randomized frames vs a string-level model.
module tb_hex_scroll_decoder;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  seg_in;
    logic        seg_valid;
    logic        seg_last;
    logic [31:0] frame_codes;
    logic        frame_done;
    logic        hello_match;
    logic [2:0]  rot_idx;
    logic        step_ok;
    logic        frame_err;
`ifdef HEX_SCROLL_DEC_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    string MSG  = "HELLO   ";
    string ALPH = "HELO ";

    int          m_prev;
    bit          m_match;
    int          m_rot;
    bit          m_step;
    logic [31:0] m_codes;
    bit          e_done;
    bit          e_err;
    int          m_errcnt;

    always #5 clk = ~clk;

    hex_scroll_decoder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .seg_in      (seg_in),
        .seg_valid   (seg_valid),
        .seg_last    (seg_last),
        .frame_codes (frame_codes),
        .frame_done  (frame_done),
        .hello_match (hello_match),
        .rot_idx     (rot_idx),
        .step_ok     (step_ok),
        .frame_err   (frame_err)
`ifdef HEX_SCROLL_DEC_ERRCNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    function automatic logic [3:0] code_of_char(input byte ch);
        for (int i = 0; i < 5; i++)
            if (ALPH[i] == ch) return 4'(i);
        return 4'hF;
    endfunction

    function automatic logic [31:0] rot_codes(input int r);
        logic [31:0] v;
        for (int k = 0; k < 8; k++)
            v[k*4 +: 4] = code_of_char(MSG[(k + r) % 8]);
        return v;
    endfunction

    function automatic int find_rot(input logic [31:0] c);
        byte got;
        bit  ok;
        for (int r = 0; r < 8; r++) begin
            ok = 1'b1;
            for (int k = 0; k < 8; k++) begin
                got = (c[k*4 +: 4] <= 4'd4) ? ALPH[c[k*4 +: 4]] : "?";
                if (got != MSG[(k + r) % 8]) ok = 1'b0;
            end
            if (ok) return r;
        end
        return -1;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] c);
        logic [6:0] p;
        case (c)
            4'd0: p = 7'b0110111;
            4'd1: p = 7'b1001111;
            4'd2: p = 7'b0001110;
            4'd3: p = 7'b1111110;
            4'd4: p = 7'b0000000;
            default: begin
                do p = 7'($urandom);
                while (p inside {7'b0110111, 7'b1001111, 7'b0001110,
                                 7'b1111110, 7'b0000000});
            end
        endcase
        return ~p;
    endfunction

    function automatic logic [55:0] segs_of(input logic [31:0] c);
        logic [55:0] s;
        for (int k = 0; k < 8; k++) s[k*7 +: 7] = seg_of(c[k*4 +: 4]);
        return s;
    endfunction

    task automatic model_reset();
        m_prev = -1; m_match = 0; m_rot = 0; m_step = 0;
        m_codes = '0; m_errcnt = 0;
    endtask

    task automatic model_frame(input logic [31:0] c, input int nd);
        int r;
        bit bad;
        if (nd < 8) begin
            e_done = 0; e_err = 1; m_prev = -1;
        end else begin
            r = find_rot(c);
            bad = 0;
            for (int k = 0; k < 8; k++) if (c[k*4 +: 4] == 4'hF) bad = 1;
            e_done = 1; e_err = bad; m_codes = c;
            m_match = (r >= 0);
            m_rot = (r >= 0) ? r : 0;
            m_step = (r >= 0) && (m_prev >= 0) && (r == (m_prev + 1) % 8);
            m_prev = r;
        end
        if (e_err && m_errcnt < 255) m_errcnt++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        seg_valid = 0; seg_last = 0; reset_n = 0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            seg_valid = 0; seg_last = 0;
            @(posedge clk);
        end
        #1;
    endtask

    // Sends nd digits; the last one carries seg_last if with_last.
    task automatic drive_frame(input logic [55:0] segs, input int nd,
                               input bit with_last, input bit gaps);
        for (int k = 0; k < nd; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    seg_valid = 0; seg_last = 0;
                    @(posedge clk);
                end
            end
            @(negedge clk);
            seg_in = segs[k*7 +: 7];
            seg_valid = 1;
            seg_last = with_last && (k == nd - 1);
            @(posedge clk);
        end
        #1;
    endtask

    task automatic test_reset();
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset done got %0b want 0", frame_done); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset err got %0b want 0", frame_err); end
        n_cmp++; if (hello_match !== 1'b0) begin n_bad++; $display("FAIL reset match got %0b want 0", hello_match); end
        n_cmp++; if (rot_idx !== 3'd0) begin n_bad++; $display("FAIL reset rot got %0d want 0", rot_idx); end
        n_cmp++; if (step_ok !== 1'b0) begin n_bad++; $display("FAIL reset step got %0b want 0", step_ok); end
        n_cmp++; if (frame_codes !== 32'h0) begin n_bad++; $display("FAIL reset codes got %h want 0", frame_codes); end
    endtask

    task automatic test_hello();
        drive_frame(segs_of(rot_codes(0)), 8, 1, 0);
        n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL hello done got %0b want 1", frame_done); end
        n_cmp++; if (hello_match !== 1'b1) begin n_bad++; $display("FAIL hello match got %0b want 1", hello_match); end
        n_cmp++; if (rot_idx !== 3'd0) begin n_bad++; $display("FAIL hello rot got %0d want 0", rot_idx); end
        n_cmp++; if (step_ok !== 1'b0) begin n_bad++; $display("FAIL hello step got %0b want 0", step_ok); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL hello err got %0b want 0", frame_err); end
        n_cmp++; if (frame_codes !== 32'h44432210) begin n_bad++; $display("FAIL hello codes got %h want 44432210", frame_codes); end
        idle(1);
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL hello pulse got %0b want 0", frame_done); end
        n_cmp++; if (hello_match !== 1'b1) begin n_bad++; $display("FAIL hello hold got %0b want 1", hello_match); end
    endtask

    task automatic test_back_to_back();
        int r;
        for (int i = 0; i < 9; i++) begin
            r = i % 8;
            drive_frame(segs_of(rot_codes(r)), 8, 1, 0);
            n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL b2b[%0d] done got %0b want 1", i, frame_done); end
            n_cmp++; if (hello_match !== 1'b1) begin n_bad++; $display("FAIL b2b[%0d] match got %0b want 1", i, hello_match); end
            n_cmp++; if (rot_idx !== 3'(r)) begin n_bad++; $display("FAIL b2b[%0d] rot got %0d want %0d", i, rot_idx, r); end
            n_cmp++; if (step_ok !== (i != 0)) begin n_bad++; $display("FAIL b2b[%0d] step got %0b want %0b", i, step_ok, i != 0); end
            n_cmp++; if (frame_codes !== rot_codes(r)) begin n_bad++; $display("FAIL b2b[%0d] codes got %h want %h", i, frame_codes, rot_codes(r)); end
        end
        idle(1);
    endtask

    task automatic test_bad_digit();
        logic [55:0] s;
        s = segs_of(rot_codes(1));
        s[3*7 +: 7] = 7'b0000000;
        drive_frame(s, 8, 1, 0);
        n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL bad done got %0b want 1", frame_done); end
        n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL bad err got %0b want 1", frame_err); end
        n_cmp++; if (hello_match !== 1'b0) begin n_bad++; $display("FAIL bad match got %0b want 0", hello_match); end
        n_cmp++; if (step_ok !== 1'b0) begin n_bad++; $display("FAIL bad step got %0b want 0", step_ok); end
        n_cmp++; if (frame_codes[15:12] !== 4'hF) begin n_bad++; $display("FAIL bad code3 got %h want F", frame_codes[15:12]); end
        drive_frame(segs_of(rot_codes(2)), 8, 1, 0);
        n_cmp++; if (hello_match !== 1'b1) begin n_bad++; $display("FAIL after-bad match got %0b want 1", hello_match); end
        n_cmp++; if (rot_idx !== 3'd2) begin n_bad++; $display("FAIL after-bad rot got %0d want 2", rot_idx); end
        n_cmp++; if (step_ok !== 1'b0) begin n_bad++; $display("FAIL after-bad step got %0b want 0", step_ok); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL after-bad err got %0b want 0", frame_err); end
        idle(1);
    endtask

    task automatic test_framing();
        drive_frame(segs_of(rot_codes(3)), 5, 1, 0);
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL short done got %0b want 0", frame_done); end
        n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL short err got %0b want 1", frame_err); end
        n_cmp++; if (rot_idx !== 3'd2) begin n_bad++; $display("FAIL short hold got %0d want 2", rot_idx); end
        drive_frame(segs_of(rot_codes(2)), 8, 1, 0);
        n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL post-short done got %0b want 1", frame_done); end
        n_cmp++; if (hello_match !== 1'b1) begin n_bad++; $display("FAIL post-short match got %0b want 1", hello_match); end
        n_cmp++; if (step_ok !== 1'b0) begin n_bad++; $display("FAIL post-short step got %0b want 0", step_ok); end
        drive_frame(segs_of(rot_codes(3)), 8, 1, 0);
        n_cmp++; if (step_ok !== 1'b1) begin n_bad++; $display("FAIL next step got %0b want 1", step_ok); end
        drive_frame(segs_of(rot_codes(4)), 8, 0, 0);
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL long done got %0b want 0", frame_done); end
        n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL long err got %0b want 1", frame_err); end
        drive_frame(segs_of(rot_codes(4)), 3, 1, 0);
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL drop done got %0b want 0", frame_done); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL drop err got %0b want 0", frame_err); end
        drive_frame(segs_of(rot_codes(3)), 8, 1, 0);
        n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL post-drop done got %0b want 1", frame_done); end
        n_cmp++; if (rot_idx !== 3'd3) begin n_bad++; $display("FAIL post-drop rot got %0d want 3", rot_idx); end
        idle(1);
    endtask

    task automatic test_reset_mid();
        drive_frame(segs_of(rot_codes(4)), 4, 0, 0);
        seg_valid = 0; seg_last = 0; reset_n = 0;
        #1;
        n_cmp++; if (hello_match !== 1'b0) begin n_bad++; $display("FAIL rstmid match got %0b want 0", hello_match); end
        n_cmp++; if (rot_idx !== 3'd0) begin n_bad++; $display("FAIL rstmid rot got %0d want 0", rot_idx); end
        n_cmp++; if (frame_codes !== 32'h0) begin n_bad++; $display("FAIL rstmid codes got %h want 0", frame_codes); end
        @(negedge clk);
        reset_n = 1;
        drive_frame(segs_of(rot_codes(4)), 8, 1, 0);
        n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL rstmid done got %0b want 1", frame_done); end
        n_cmp++; if (rot_idx !== 3'd4) begin n_bad++; $display("FAIL rstmid rot2 got %0d want 4", rot_idx); end
        n_cmp++; if (step_ok !== 1'b0) begin n_bad++; $display("FAIL rstmid step got %0b want 0", step_ok); end
        idle(1);
    endtask

    task automatic test_random();
        logic [31:0] c;
        int kind, nd, r;
        do_reset();
        model_reset();
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            nd = 8;
            r = (m_prev >= 0 && $urandom_range(0, 9) < 7) ? (m_prev + 1) % 8 : $urandom_range(0, 7);
            c = rot_codes(r);
            if (kind == 0) nd = $urandom_range(1, 7);
            else if (kind == 1) c[$urandom_range(0, 7)*4 +: 4] = 4'hF;
            else if (kind == 2) for (int k = 0; k < 8; k++) c[k*4 +: 4] = 4'($urandom_range(0, 4));
            model_frame(c, nd);
            drive_frame(segs_of(c), nd, 1, 1);
            n_cmp++; if (frame_done !== e_done) begin n_bad++; $display("FAIL rnd[%0d] done got %0b want %0b", i, frame_done, e_done); end
            n_cmp++; if (frame_err !== e_err) begin n_bad++; $display("FAIL rnd[%0d] err got %0b want %0b", i, frame_err, e_err); end
            n_cmp++; if (hello_match !== m_match) begin n_bad++; $display("FAIL rnd[%0d] match got %0b want %0b", i, hello_match, m_match); end
            n_cmp++; if (rot_idx !== 3'(m_rot)) begin n_bad++; $display("FAIL rnd[%0d] rot got %0d want %0d", i, rot_idx, m_rot); end
            n_cmp++; if (step_ok !== m_step) begin n_bad++; $display("FAIL rnd[%0d] step got %0b want %0b", i, step_ok, m_step); end
            n_cmp++; if (frame_codes !== m_codes) begin n_bad++; $display("FAIL rnd[%0d] codes got %h want %h", i, frame_codes, m_codes); end
`ifdef HEX_SCROLL_DEC_ERRCNT_EN
            n_cmp++; if (err_cnt !== 8'(m_errcnt)) begin n_bad++; $display("FAIL rnd[%0d] errcnt got %0d want %0d", i, err_cnt, m_errcnt); end
`endif
        end
        idle(1);
    endtask

`ifdef HEX_SCROLL_DEC_ERRCNT_EN
    task automatic test_errcnt();
        logic [55:0] s;
        s = segs_of(rot_codes(0));
        for (int i = 0; i < 300; i++) begin
            model_frame(rot_codes(0), 1);
            drive_frame(s, 1, 1, 0);
        end
        idle(1);
        n_cmp++; if (err_cnt !== 8'(m_errcnt)) begin n_bad++; $display("FAIL errcnt model got %0d want %0d", err_cnt, m_errcnt); end
        n_cmp++; if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL errcnt sat got %0d want 255", err_cnt); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        seg_in = 7'h7F; seg_valid = 0; seg_last = 0; reset_n = 0;
        do_reset();
        #1;
        test_reset();
        test_hello();
        test_back_to_back();
        test_bad_digit();
        test_framing();
        test_reset_mid();
        test_random();
`ifdef HEX_SCROLL_DEC_ERRCNT_EN
        test_errcnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
